fwd_scoreboard: RTL

Parametrised forwarding and hazard-detection block for the pipelined RISC-V core. It sits between decode (ID) and execute (EX). Per-register countdown counters track in-flight writes of variable latency (ALU, load, multi-cycle mul/div), and from them the block raises a stall for the instruction in ID. It also generates EX/MEM and MEM/WB forwarding selects for NUM_SRC source operands of the instruction in EX, and counts stall cycles for performance monitoring.

---
 rtl/fwd_scoreboard.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Hazard detection and operand forwarding for the pipelined
//            RISC-V core, placed between decode (ID) and execute (EX).
//            One countdown counter per architectural register tracks an
//            in-flight write of variable latency (ALU, load, mul/div). From
//            these counters the block stalls the instruction in ID on RAW
//            and WAW hazards. It also produces EX/MEM and MEM/WB forwarding
//            selects for the source operands of the instruction in EX, and
//            counts stall cycles for performance monitoring.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i              core clock, rising edge
//   rst_ni             asynchronous active-low reset
//   issue_valid_i      instruction in ID is valid
//   issue_regwrite_i   instruction in ID writes rd
//   issue_rd_i         destination register of the ID instruction
//   issue_latency_i    cycles until the result can be forwarded (0 = untracked)
//   issue_rs_i         ID source registers, operand i at [5i+4:5i]
//   flush_i            kill the instruction in ID this cycle
//   hazard_selector_i  force every forwarding select to 00
//   ex_mem_regwrite_i  EX/MEM stage writes its rd
//   ex_mem_rd_i        EX/MEM destination register
//   mem_wb_regwrite_i  MEM/WB stage writes its rd
//   mem_wb_rd_i        MEM/WB destination register
//   id_ex_rs_i         EX source registers, same packing as issue_rs_i
//   forward_o          operand i at [2i+1:2i]: 00 RF, 10 EX/MEM, 01 MEM/WB
//   stall_o            hold PC and IF/ID, insert a bubble into ID/EX
//   busy_mask_o        bit r set while counter[r] != 0
//   stall_count_o      saturating count of stalled cycles
// ============================================================================
`default_nettype none

module fwd_scoreboard #(
  parameter int N        = 32,
  parameter int NUM_SRC  = 2,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic                   issue_regwrite_i,
  input  logic [4:0]             issue_rd_i,
  input  logic [LAT_W-1:0]       issue_latency_i,
  input  logic [NUM_SRC*5-1:0]   issue_rs_i,
  input  logic                   flush_i,
  input  logic                   hazard_selector_i,
  input  logic                   ex_mem_regwrite_i,
  input  logic [4:0]             ex_mem_rd_i,
  input  logic                   mem_wb_regwrite_i,
  input  logic [4:0]             mem_wb_rd_i,
  input  logic [NUM_SRC*5-1:0]   id_ex_rs_i,
  output logic [NUM_SRC*2-1:0]   forward_o,
  output logic                   stall_o,
  output logic [NUM_REGS-1:0]    busy_mask_o,
  output logic [CNT_W-1:0]       stall_count_o
);

  // Elaboration-time sanity check of the parameter set.
  generate
    if (N < 1 || NUM_SRC < 1 || NUM_SRC > 3 || NUM_REGS < 2 || NUM_REGS > 32 ||
        LAT_W < 1 || CNT_W < 1) begin : g_bad_param
      $error("fwd_scoreboard: unsupported parameter combination");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // --------------------------------------------------------------------------
  // Counter lookups for the ID instruction
  // --------------------------------------------------------------------------
  logic [LAT_W-1:0] cnt_rs [NUM_SRC];
  logic [LAT_W-1:0] cnt_rd;

  // Index out of range (NUM_REGS < 32) or x0 reads as an idle counter.
  always_comb begin
    cnt_rd = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_rd_i == 5'(r)) cnt_rd = cnt_q[r];
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      cnt_rs[s] = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_rs_i[5*s +: 5] == 5'(r)) cnt_rs[s] = cnt_q[r];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic raw_hit;
  logic waw_hit;
  logic stall;
  logic accept;
  logic load_en;

  always_comb begin
    raw_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      // A counter of 1 means the producer result is forwardable next cycle,
      // so only values above 1 require a bubble.
      if (issue_rs_i[5*s +: 5] != 5'd0 && cnt_rs[s] > LAT_W'(1)) raw_hit = 1'b1;
    end
  end

  // A younger write must not complete before an older one to the same rd.
  assign waw_hit = issue_regwrite_i && (issue_rd_i != 5'd0) &&
                   (cnt_rd > issue_latency_i);

  assign stall   = issue_valid_i && !flush_i && (raw_hit || waw_hit);
  assign accept  = issue_valid_i && !flush_i && !stall;
  assign load_en = accept && issue_regwrite_i && (issue_rd_i != 5'd0) &&
                   (issue_latency_i != '0);

  // --------------------------------------------------------------------------
  // Next-state for counters, busy mask and stall counter
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      // A new issue overrides the decrement of the same register.
      if (load_en && issue_rd_i == 5'(r)) begin
        cnt_d[r] = issue_latency_i;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
    busy_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding selects for the EX instruction; EX/MEM has priority because
  // it holds the younger result.
  // --------------------------------------------------------------------------
  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
      logic [4:0] rs;
      logic       ex_hit;
      logic       wb_hit;
      assign rs     = id_ex_rs_i[5*s +: 5];
      assign ex_hit = ex_mem_regwrite_i && (ex_mem_rd_i != 5'd0) && (ex_mem_rd_i == rs);
      assign wb_hit = mem_wb_regwrite_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rs);
      assign forward_o[2*s +: 2] = hazard_selector_i ? 2'b00 :
                                   ex_hit            ? 2'b10 :
                                   wb_hit            ? 2'b01 : 2'b00;
    end
  endgenerate

  assign stall_o       = stall;
  assign busy_mask_o   = busy_q;
  assign stall_count_o = stall_cnt_q;

endmodule

`default_nettype wire
